qdec_error: RTL and testbench

- Feeder for the PID controller array, on the input side of the PID loop.
- Decodes one quadrature encoder per PID channel (x4 decoding) into signed position counters and holds a per-channel setpoint.
- Presents the saturated error (setpoint − position) for the channel selected by the PID's address bus.
- Sits between encoder pins and the PID's error input, sharing clk_pid and the PID address.

---
 rtl/qdec_error_if.sv | 35 +++
 rtl/qdec_error.sv | 222 ++++++++++++++++++++++
 tb/tb_qdec_error.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qdec_error_if.sv
// rtl/qdec_error_if.sv - PID-side register/readout bus of the quadrature decoder
//
// Purpose: groups the PID address, setpoint/clear write strobes and the
//   per-channel readout (error, position, fault) into one bundle.
// Parameters: aw (address width), ew (data width), an (channel count).
// Modports:
//   master - PID / host side: drives a, sp_we, pos_clr, wr_addr, sp_data;
//            receives error, position, fault.
//   slave  - decoder side: the mirror image.
interface qdec_error_if #(
  parameter int aw = 1,
  parameter int ew = 24,
  parameter int an = 1 << aw
);

  logic        [aw-1:0] a;
  logic                 sp_we;
  logic                 pos_clr;
  logic        [aw-1:0] wr_addr;
  logic signed [ew-1:0] sp_data;
  logic signed [ew-1:0] error;
  logic signed [ew-1:0] position;
  logic        [an-1:0] fault;

  modport master (
    output a, sp_we, pos_clr, wr_addr, sp_data,
    input  error, position, fault
  );

  modport slave (
    input  a, sp_we, pos_clr, wr_addr, sp_data,
    output error, position, fault
  );

endinterface

// File: rtl/qdec_error.sv
// rtl/qdec_error.sv - x4 quadrature decoder bank feeding saturated error to the PID array
//
// Purpose: one quadrature encoder per PID channel is synchronised, decoded
//   (x4) into a signed position counter and compared against a per-channel
//   setpoint. The saturated difference (setpoint - position) and the position
//   of the channel addressed by the PID are presented as registered outputs.
//
// Optional build macro: QDEC_FILTER_EN
//   Defined   - each synchronised phase bit passes a stability filter and only
//               changes after differing from its filtered value for 2^filt
//               consecutive clocks (pin-to-counter latency 3 + 2^filt clocks).
//   Undefined - synchronised bits feed the decoder directly (latency 3 clocks).
//
// Ports:
//   clk_pid  in   PID/system clock
//   reset    in   asynchronous active-low reset
//   enc_a    in   [an] encoder phase A per channel (asynchronous pins)
//   enc_b    in   [an] encoder phase B per channel (asynchronous pins)
//   bus      slave modport of qdec_error_if:
//     a        in   channel presented on error/position
//     sp_we    in   setpoint write strobe (one clock)
//     pos_clr  in   position/fault clear strobe (one clock)
//     wr_addr  in   channel targeted by sp_we / pos_clr
//     sp_data  in   signed setpoint value
//     error    out  registered sat(setpoint[a] - position[a])
//     position out  registered position[a]
//     fault    out  [an] sticky illegal-transition flags
module qdec_error #(
  parameter int aw   = 1,
  parameter int an   = 1 << aw,
  parameter int ew   = 24,
  parameter int filt = 3
) (
  input  logic          clk_pid,
  input  logic          reset,
  input  logic [an-1:0] enc_a,
  input  logic [an-1:0] enc_b,
  qdec_error_if.slave   bus
);

  // Elaboration-time sanity checks on the configuration.
  if (filt < 1) begin : g_bad_filt
    $error("qdec_error: filt must be at least 1");
  end
  if (an > (1 << aw)) begin : g_bad_an
    $error("qdec_error: an exceeds the address range of aw");
  end

  localparam logic signed [ew-1:0] ERR_MAX = {1'b0, {(ew-1){1'b1}}};
  localparam logic signed [ew-1:0] ERR_MIN = {1'b1, {(ew-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for the asynchronous encoder pins
  // ---------------------------------------------------------------------------
  logic [an-1:0] sync_a1, sync_a2;
  logic [an-1:0] sync_b1, sync_b2;

  always_ff @(posedge clk_pid or negedge reset) begin
    if (!reset) begin
      sync_a1 <= '0;
      sync_a2 <= '0;
      sync_b1 <= '0;
      sync_b2 <= '0;
    end else begin
      sync_a1 <= enc_a;
      sync_a2 <= sync_a1;
      sync_b1 <= enc_b;
      sync_b2 <= sync_b1;
    end
  end

  // Phase bits as seen by the decoder.
  logic [an-1:0] dec_a;
  logic [an-1:0] dec_b;

`ifdef QDEC_FILTER_EN
  // ---------------------------------------------------------------------------
  // Stability filter: a filtered bit follows its synced input only after the
  // two have disagreed for 2^filt consecutive clocks. Any agreement restarts
  // the run, so shorter pulses never reach the decoder.
  // ---------------------------------------------------------------------------
  logic [filt-1:0] run_a [an];
  logic [filt-1:0] run_b [an];
  logic [an-1:0]   filt_a;
  logic [an-1:0]   filt_b;

  always_ff @(posedge clk_pid or negedge reset) begin
    if (!reset) begin
      filt_a <= '0;
      filt_b <= '0;
      for (int ch = 0; ch < an; ch++) begin
        run_a[ch] <= '0;
        run_b[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < an; ch++) begin
        if (sync_a2[ch] == filt_a[ch]) begin
          run_a[ch] <= '0;
        end else if (&run_a[ch]) begin
          filt_a[ch] <= sync_a2[ch];
          run_a[ch]  <= '0;
        end else begin
          run_a[ch] <= run_a[ch] + 1'b1;
        end

        if (sync_b2[ch] == filt_b[ch]) begin
          run_b[ch] <= '0;
        end else if (&run_b[ch]) begin
          filt_b[ch] <= sync_b2[ch];
          run_b[ch]  <= '0;
        end else begin
          run_b[ch] <= run_b[ch] + 1'b1;
        end
      end
    end
  end

  assign dec_a = filt_a;
  assign dec_b = filt_b;
`else
  assign dec_a = sync_a2;
  assign dec_b = sync_b2;
`endif

  // ---------------------------------------------------------------------------
  // x4 decode: compare the current {A,B} against the value seen last clock.
  // Forward Gray order is 00 -> 01 -> 11 -> 10 -> 00.
  // ---------------------------------------------------------------------------
  logic [1:0]    prev [an];
  logic [an-1:0] step_inc;
  logic [an-1:0] step_dec;
  logic [an-1:0] step_bad;

  always_comb begin
    step_inc = '0;
    step_dec = '0;
    step_bad = '0;
    for (int ch = 0; ch < an; ch++) begin
      case ({prev[ch], dec_a[ch], dec_b[ch]})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_inc[ch] = 1'b1;
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_dec[ch] = 1'b1;
        // Both phases moved at once: direction is unknowable.
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad[ch] = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel state: previous phases, position, setpoint, sticky fault.
  // A clear on a channel overrides a same-clock count or fault on it.
  // ---------------------------------------------------------------------------
  logic signed [ew-1:0] pos [an];
  logic signed [ew-1:0] sp  [an];
  logic [an-1:0]        flt;

  always_ff @(posedge clk_pid or negedge reset) begin
    if (!reset) begin
      flt <= '0;
      for (int ch = 0; ch < an; ch++) begin
        prev[ch] <= 2'b00;
        pos[ch]  <= '0;
        sp[ch]   <= '0;
      end
    end else begin
      for (int ch = 0; ch < an; ch++) begin
        prev[ch] <= {dec_a[ch], dec_b[ch]};

        if (bus.pos_clr && (bus.wr_addr == aw'(ch))) begin
          pos[ch] <= '0;
          flt[ch] <= 1'b0;
        end else begin
          // Wraps silently in two's complement at the extremes.
          if (step_inc[ch]) begin
            pos[ch] <= pos[ch] + 1'b1;
          end else if (step_dec[ch]) begin
            pos[ch] <= pos[ch] - 1'b1;
          end
          if (step_bad[ch]) begin
            flt[ch] <= 1'b1;
          end
        end

        if (bus.sp_we && (bus.wr_addr == aw'(ch))) begin
          sp[ch] <= bus.sp_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Error path: subtract in ew+1 bits, clamp when the top two bits disagree.
  // ---------------------------------------------------------------------------
  logic signed [ew-1:0] sel_sp;
  logic signed [ew-1:0] sel_pos;
  logic        [ew:0]   diff;
  logic signed [ew-1:0] err_next;

  assign sel_sp  = sp[bus.a];
  assign sel_pos = pos[bus.a];
  assign diff    = {sel_sp[ew-1], sel_sp} - {sel_pos[ew-1], sel_pos};

  always_comb begin
    err_next = diff[ew-1:0];
    if (diff[ew] != diff[ew-1]) begin
      err_next = diff[ew] ? ERR_MIN : ERR_MAX;
    end
  end

  always_ff @(posedge clk_pid or negedge reset) begin
    if (!reset) begin
      bus.error    <= '0;
      bus.position <= '0;
    end else begin
      bus.error    <= err_next;
      bus.position <= sel_pos;
    end
  end

  assign bus.fault = flt;

endmodule

// File: tb/tb_qdec_error.sv
// tb/tb_qdec_error.sv - directed self-checking bench for qdec_error
module tb_qdec_error;

`ifdef QDEC_FILTER_EN
  localparam int LAT = 11;
  localparam int GAP = 12;
`else
  localparam int LAT = 3;
  localparam int GAP = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] enc_a, enc_b;
  logic [1:0] wa, wb;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] gray [4];
  int         idx [2];
  int         widx;

  always #5 clk = ~clk;

  qdec_error_if #(.aw(1), .ew(24)) bus ();
  qdec_error_if #(.aw(1), .ew(4))  bus_w ();

  qdec_error #(.aw(1), .ew(24)) dut (
    .clk_pid (clk),
    .reset   (rst_n),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .bus     (bus.slave)
  );

  qdec_error #(.aw(1), .ew(4)) dut_w (
    .clk_pid (clk),
    .reset   (rst_n),
    .enc_a   (wa),
    .enc_b   (wb),
    .bus     (bus_w.slave)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step(input int ch, input int dir);
    idx[ch] = (idx[ch] + dir) & 3;
    enc_a[ch] = gray[idx[ch]][1];
    enc_b[ch] = gray[idx[ch]][0];
  endtask

  task automatic wstep(input int dir);
    widx = (widx + dir) & 3;
    wa[0] = gray[widx][1];
    wb[0] = gray[widx][0];
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.a = '0; bus.sp_we = 1'b0; bus.pos_clr = 1'b0; bus.wr_addr = '0; bus.sp_data = '0;
    bus_w.a = '0; bus_w.sp_we = 1'b0; bus_w.pos_clr = 1'b0; bus_w.wr_addr = '0; bus_w.sp_data = '0;
    wa = '0; wb = '0;
    for (int i = 0; i < 8; i++) begin
      enc_a = 2'($urandom);
      enc_b = 2'($urandom);
      tick(1);
    end
    vectors++;
    if (bus.error !== 24'h0) begin
      miscompares++; $display("FAIL rst_error got %h want 000000", bus.error);
    end
    vectors++;
    if (bus.position !== 24'h0) begin
      miscompares++; $display("FAIL rst_position got %h want 000000", bus.position);
    end
    vectors++;
    if (bus.fault !== 2'b00) begin
      miscompares++; $display("FAIL rst_fault got %b want 00", bus.fault);
    end
    enc_a = '0; enc_b = '0; idx[0] = 0; idx[1] = 0; widx = 0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    vectors++;
    if (bus.error !== 24'h0 || bus.position !== 24'h0 || bus.fault !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset got err=%h pos=%h fault=%b want all zero",
               bus.error, bus.position, bus.fault);
    end
  endtask

  task automatic test_forward;
    logic [23:0] exp_old, exp_new;
    bus.a = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      exp_old = 24'(-(s - 1));
      exp_new = 24'(-s);
      step(0, 1);
      tick(LAT);
      vectors++;
      if (bus.error !== exp_old) begin
        miscompares++; $display("FAIL fwd_early step%0d got %h want %h", s, bus.error, exp_old);
      end
      tick(1);
      vectors++;
      if (bus.error !== exp_new) begin
        miscompares++; $display("FAIL fwd_error step%0d got %h want %h", s, bus.error, exp_new);
      end
      vectors++;
      if (bus.position !== 24'(s)) begin
        miscompares++; $display("FAIL fwd_position step%0d got %h want %h", s, bus.position, 24'(s));
      end
      tick(6);
    end
  endtask

  task automatic test_reverse_sp;
    bus.sp_we = 1'b1; bus.wr_addr = 1'b1; bus.sp_data = 24'd1000;
    tick(1);
    bus.sp_we = 1'b0;
    bus.a = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step(1, -1);
      tick(GAP);
    end
    tick(LAT + 2);
    vectors++;
    if (bus.position !== 24'hFFFFFD) begin
      miscompares++; $display("FAIL rev_position got %h want fffffd", bus.position);
    end
    vectors++;
    if (bus.error !== 24'd1003) begin
      miscompares++; $display("FAIL rev_error got %0d want 1003", bus.error);
    end
    bus.a = 1'b0;
    tick(1);
    vectors++;
    if (bus.position !== 24'd4 || bus.error !== 24'hFFFFFC) begin
      miscompares++;
      $display("FAIL ch0_unaffected got pos=%h err=%h want 000004/fffffc", bus.position, bus.error);
    end
  endtask

  task automatic test_illegal;
    bus.a = 1'b0;
    idx[0] = 2;
    enc_a[0] = 1'b1; enc_b[0] = 1'b1;
    tick(LAT + 2);
    vectors++;
    if (bus.position !== 24'd4) begin
      miscompares++; $display("FAIL illegal_position got %h want 000004", bus.position);
    end
    vectors++;
    if (bus.fault !== 2'b01) begin
      miscompares++; $display("FAIL illegal_fault got %b want 01", bus.fault);
    end
    tick(5);
    vectors++;
    if (bus.fault !== 2'b01) begin
      miscompares++; $display("FAIL fault_sticky got %b want 01", bus.fault);
    end
    bus.pos_clr = 1'b1; bus.wr_addr = 1'b0;
    tick(1);
    bus.pos_clr = 1'b0;
    tick(1);
    vectors++;
    if (bus.position !== 24'd0 || bus.fault !== 2'b00) begin
      miscompares++;
      $display("FAIL pos_clr got pos=%h fault=%b want 000000/00", bus.position, bus.fault);
    end
    step(0, 1);
    tick(LAT - 1);
    bus.pos_clr = 1'b1; bus.wr_addr = 1'b0;
    tick(1);
    bus.pos_clr = 1'b0;
    tick(4);
    vectors++;
    if (bus.position !== 24'd0 || bus.error !== 24'd0) begin
      miscompares++;
      $display("FAIL clr_beats_count got pos=%h err=%h want 000000/000000", bus.position, bus.error);
    end
  endtask

  task automatic test_saturation;
    bus.a = 1'b0;
    bus.pos_clr = 1'b1; bus.wr_addr = 1'b0;
    tick(1);
    bus.pos_clr = 1'b0;
    for (int s = 0; s < 10; s++) begin
      step(0, -1);
      tick(GAP);
    end
    bus.sp_we = 1'b1; bus.sp_data = 24'h7FFFFF;
    tick(1);
    bus.sp_we = 1'b0;
    tick(LAT + 2);
    vectors++;
    if (bus.position !== 24'hFFFFF6) begin
      miscompares++; $display("FAIL sat_pos_neg got %h want fffff6", bus.position);
    end
    vectors++;
    if (bus.error !== 24'h7FFFFF) begin
      miscompares++; $display("FAIL sat_high got %h want 7fffff", bus.error);
    end
    bus.pos_clr = 1'b1; bus.sp_we = 1'b1; bus.sp_data = 24'h800000;
    tick(1);
    bus.pos_clr = 1'b0; bus.sp_we = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step(0, 1);
      tick(GAP);
    end
    tick(LAT + 2);
    vectors++;
    if (bus.position !== 24'd5) begin
      miscompares++; $display("FAIL sat_pos_pos got %h want 000005", bus.position);
    end
    vectors++;
    if (bus.error !== 24'h800000) begin
      miscompares++; $display("FAIL sat_low got %h want 800000", bus.error);
    end
    bus.sp_we = 1'b1; bus.sp_data = 24'h800005;
    tick(1);
    bus.sp_we = 1'b0;
    tick(2);
    vectors++;
    if (bus.error !== 24'h800000) begin
      miscompares++; $display("FAIL exact_min got %h want 800000", bus.error);
    end
  endtask

  task automatic test_wrap;
    for (int s = 0; s < 7; s++) begin
      wstep(1);
      tick(GAP);
    end
    tick(LAT + 2);
    vectors++;
    if (bus_w.position !== 4'h7 || bus_w.error !== 4'h9) begin
      miscompares++;
      $display("FAIL wrap_max got pos=%h err=%h want 7/9", bus_w.position, bus_w.error);
    end
    wstep(1);
    tick(LAT + 2);
    vectors++;
    if (bus_w.position !== 4'h8) begin
      miscompares++; $display("FAIL wrap_over got %h want 8", bus_w.position);
    end
    vectors++;
    if (bus_w.error !== 4'h7) begin
      miscompares++; $display("FAIL wrap_err_clamp got %h want 7", bus_w.error);
    end
    wstep(-1);
    tick(LAT + 2);
    vectors++;
    if (bus_w.position !== 4'h7) begin
      miscompares++; $display("FAIL wrap_back got %h want 7", bus_w.position);
    end
  endtask

`ifndef QDEC_FILTER_EN
  task automatic test_back_to_back;
    bus.a = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step(1, 1);
      tick(1);
    end
    tick(LAT + 2);
    vectors++;
    if (bus.position !== 24'd1 || bus.fault[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back got pos=%h fault1=%b want 000001/0", bus.position, bus.fault[1]);
    end
    vectors++;
    if (bus.error !== 24'd999) begin
      miscompares++; $display("FAIL b2b_error got %0d want 999", bus.error);
    end
  endtask
`else
  task automatic test_filter;
    bus.a = 1'b0;
    enc_a[0] = ~enc_a[0];
    tick(5);
    enc_a[0] = ~enc_a[0];
    tick(20);
    vectors++;
    if (bus.position !== 24'd5 || bus.fault[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_ignored got pos=%h fault0=%b want 000005/0", bus.position, bus.fault[0]);
    end
    step(0, 1);
    tick(LAT);
    vectors++;
    if (bus.position !== 24'd5) begin
      miscompares++; $display("FAIL filt_early got %h want 000005", bus.position);
    end
    tick(1);
    vectors++;
    if (bus.position !== 24'd6) begin
      miscompares++; $display("FAIL filt_count got %h want 000006", bus.position);
    end
  endtask
`endif

  task automatic test_reset_mid;
    bus.a = 1'b0;
    step(0, 1);
    tick(LAT - 1);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.position !== 24'd0 || bus.error !== 24'd0 || bus.fault !== 2'b00 ||
        bus_w.position !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_mid got pos=%h err=%h fault=%b wpos=%h want all zero",
               bus.position, bus.error, bus.fault, bus_w.position);
    end
    enc_a = '0; enc_b = '0; wa = '0; wb = '0;
    tick(3);
    rst_n = 1'b1;
    tick(LAT + 4);
    vectors++;
    if (bus.position !== 24'd0 || bus.error !== 24'd0) begin
      miscompares++;
      $display("FAIL after_mid_reset got pos=%h err=%h want 000000/000000", bus.position, bus.error);
    end
  endtask

  initial begin
    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    test_reset();
    test_forward();
    test_reverse_sp();
    test_illegal();
    test_saturation();
    test_wrap();
`ifndef QDEC_FILTER_EN
    test_back_to_back();
`else
    test_filter();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
